// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the fetch stage's redirect, MMU read and decode-side handshake
//   signals. CLK and RST stay as plain ports on the modules that use this.
//
//   Redirect   : JMP_DO, JMP_PC                      (exec -> fetch)
//   MMU request: MEM_WAIT (in), INST_RDEN, INST_RIADDR (out)
//   MMU reply  : INST_RVALID, INST_ROADDR, INST_RDATA (in)
//   Decode side: OUT_VALID, OUT_PC, OUT_DATA, COUNT (out), OUT_READY (in)
//
//   master = the fetch queue, slave = its environment.
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = $clog2(QUEUE_DEPTH) + 1
);
    logic             JMP_DO;
    logic [31:0]      JMP_PC;
    logic             MEM_WAIT;
    logic             INST_RDEN;
    logic [31:0]      INST_RIADDR;
    logic             INST_RVALID;
    logic [31:0]      INST_ROADDR;
    logic [31:0]      INST_RDATA;
    logic             OUT_VALID;
    logic [31:0]      OUT_PC;
    logic [31:0]      OUT_DATA;
    logic             OUT_READY;
    logic [CNT_W-1:0] COUNT;

    modport master (
        input  JMP_DO, JMP_PC, MEM_WAIT, INST_RVALID, INST_ROADDR, INST_RDATA, OUT_READY,
        output INST_RDEN, INST_RIADDR, OUT_VALID, OUT_PC, OUT_DATA, COUNT
    );

    modport slave (
        output JMP_DO, JMP_PC, MEM_WAIT, INST_RVALID, INST_ROADDR, INST_RDATA, OUT_READY,
        input  INST_RDEN, INST_RIADDR, OUT_VALID, OUT_PC, OUT_DATA, COUNT
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch stage with several reads in flight. Generates the PC,
//   issues reads to the MMU while queued + in-flight entries are below
//   QUEUE_DEPTH, and buffers the in-order responses in a first-word-fall-
//   through queue toward decode_1st. A jump redirects the PC, flushes the
//   queue and turns every outstanding read into one to be discarded.
//
//   Ports:
//     CLK  clock
//     RST  synchronous active-high reset
//     bus  fetch_queue_if.master (redirect, MMU request/reply, decode output)
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter logic [31:0] START_ADDR  = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input logic           CLK,
    input logic           RST,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    // Discards can pile up across back-to-back redirects while a slow MMU is
    // still answering older reads, so this counter gets extra headroom.
    localparam int DISC_W = CNT_W + 2;
    localparam logic [CNT_W:0] DEPTH_CMP = (CNT_W+1)'(QUEUE_DEPTH);

    // Architectural state
    logic [31:0]       r_pc;
    logic [CNT_W-1:0]  r_inflight;
    logic [DISC_W-1:0] r_discard;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [31:0]       r_out_pc;
    logic [31:0]       r_out_data;
    logic [63:0]       r_mem [QUEUE_DEPTH];   // {pc, instruction}

    // Next-state and decode
    logic [31:0]       w_pc_next;
    logic [CNT_W-1:0]  w_inflight_next;
    logic [DISC_W-1:0] w_discard_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [CNT_W-1:0]  w_count_after_pop;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [31:0]       w_out_pc_next;
    logic [31:0]       w_out_data_next;
    logic [CNT_W:0]    w_occupancy;
    logic [DISC_W-1:0] w_stale;
    logic              w_issue;
    logic              w_drop_resp;
    logic              w_take_resp;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    assign w_occupancy = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue     = !RST && !bus.MEM_WAIT && !bus.JMP_DO && (w_occupancy < DEPTH_CMP);

    // Responses arrive in request order, so pending discards always belong to
    // the oldest outstanding reads and are consumed first.
    assign w_drop_resp = bus.INST_RVALID && (r_discard != '0);
    assign w_take_resp = bus.INST_RVALID && (r_discard == '0) && (r_inflight != '0);
    assign w_push      = w_take_resp && !bus.JMP_DO;
    assign w_pop       = (r_count != '0) && bus.OUT_READY && !bus.JMP_DO;

    // Everything still outstanding at a redirect becomes stale.
    assign w_stale     = r_discard + DISC_W'(r_inflight);

    assign w_unused    = ^bus.JMP_PC[1:0];

    always_comb begin
        w_pc_next         = r_pc;
        w_inflight_next   = r_inflight;
        w_discard_next    = r_discard;
        w_count_next      = r_count;
        w_wr_ptr_next     = r_wr_ptr;
        w_rd_ptr_next     = r_rd_ptr;
        w_out_pc_next     = r_out_pc;
        w_out_data_next   = r_out_data;
        w_count_after_pop = r_count - CNT_W'(w_pop);

        if (bus.JMP_DO) begin
            w_pc_next       = {bus.JMP_PC[31:2], 2'b00};
            w_inflight_next = '0;
            // A response landing in the redirect cycle is one of the stale
            // reads and is dropped right here.
            w_discard_next  = w_stale - DISC_W'(bus.INST_RVALID && (w_stale != '0));
            w_count_next    = '0;
            w_wr_ptr_next   = '0;
            w_rd_ptr_next   = '0;
        end else begin
            if (w_issue) begin
                w_pc_next = r_pc + 32'd4;
            end
            if (w_drop_resp) begin
                w_discard_next = r_discard - DISC_W'(1);
            end
            w_inflight_next = r_inflight + CNT_W'(w_issue) - CNT_W'(w_take_resp);
            w_count_next    = w_count_after_pop + CNT_W'(w_push);
            w_wr_ptr_next   = r_wr_ptr + PTR_W'(w_push);
            w_rd_ptr_next   = r_rd_ptr + PTR_W'(w_pop);

            // Head register tracks whatever will be at the front next cycle.
            // If the queue would otherwise be empty, the incoming response is
            // forwarded directly so it shows up one cycle after arrival.
            // With nothing to show, the last head value is held.
            if (w_count_after_pop != '0) begin
                w_out_pc_next   = r_mem[w_rd_ptr_next][63:32];
                w_out_data_next = r_mem[w_rd_ptr_next][31:0];
            end else if (w_push) begin
                w_out_pc_next   = bus.INST_ROADDR;
                w_out_data_next = bus.INST_RDATA;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc       <= START_ADDR;
            r_inflight <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_pc   <= '0;
            r_out_data <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_inflight <= w_inflight_next;
            r_discard  <= w_discard_next;
            r_count    <= w_count_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_out_pc   <= w_out_pc_next;
            r_out_data <= w_out_data_next;
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.INST_ROADDR, bus.INST_RDATA};
        end
    end

    assign bus.INST_RDEN   = w_issue;
    assign bus.INST_RIADDR = r_pc;
    assign bus.OUT_VALID   = (r_count != '0);
    assign bus.OUT_PC      = r_out_pc;
    assign bus.OUT_DATA    = r_out_data;
    assign bus.COUNT       = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] START = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fetch_queue_if #(.QUEUE_DEPTH(DEPTH), .CNT_W(CW)) bus ();

    fetch_queue #(.START_ADDR(START), .QUEUE_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus controls
    bit          c_rst = 1, c_wait = 0, c_jmp = 0, c_ready = 1, rnd = 0;
    logic [31:0] c_jpc = 32'h0;
    int          lat   = 1;

    // MMU model: in-order, at most one response per cycle
    logic [31:0] mmu_addr[$];
    int          mmu_due[$];
    int          mmu_last_due = 0;

    // behavioural reference: PC, outstanding counts, queue of {pc,data}
    logic [31:0] m_pc = START;
    int          m_inflight = 0, m_discard = 0;
    logic [63:0] m_q[$];
    logic [31:0] m_last_pc = 0, m_last_data = 0;
    bit          m_known = 0;

    // observation logs
    bit          d_rden = 0;
    logic [31:0] d_addr;
    logic [31:0] req_log[$], acc_log[$];
    int          maxc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] get(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic bit exp_rden();
        return !RST && !bus.MEM_WAIT && !bus.JMP_DO && (m_q.size() + m_inflight < DEPTH);
    endfunction

    // Applies the inputs of the cycle that just ended to the reference.
    task automatic model_update();
        bit          issue, pop, push;
        int          pend;
        logic [63:0] item;
        push = 0;
        item = '0;
        if (RST) begin
            m_pc = START; m_inflight = 0; m_discard = 0; m_q.delete();
            m_last_pc = 0; m_last_data = 0; m_known = 1;
        end else if (m_known) begin
            issue = exp_rden();
            pop   = (m_q.size() != 0) && bus.OUT_READY;
            if (bus.JMP_DO) begin
                pend = m_discard + m_inflight;
                if (bus.INST_RVALID && pend > 0) pend--;
                m_discard = pend; m_inflight = 0; m_q.delete();
                m_pc = {bus.JMP_PC[31:2], 2'b00};
            end else begin
                if (bus.INST_RVALID) begin
                    if (m_discard > 0) m_discard--;
                    else if (m_inflight > 0) begin
                        m_inflight--;
                        item = {bus.INST_ROADDR, bus.INST_RDATA};
                        push = 1;
                    end
                end
                if (issue) begin m_pc = m_pc + 32'd4; m_inflight++; end
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(item);
            end
        end
    endtask

    task automatic cycle();
        int due;
        @(posedge CLK);
        #1;
        model_update();
        if (d_rden) begin
            due = cyc + lat;
            if (due <= mmu_last_due) due = mmu_last_due + 1;
            mmu_addr.push_back(d_addr);
            mmu_due.push_back(due);
            mmu_last_due = due;
        end
        cyc++;
        if (rnd) begin
            c_rst   = ($urandom % 100) == 0;
            c_wait  = ($urandom % 4) == 0;
            c_jmp   = ($urandom % 16) == 0;
            c_jpc   = $urandom;
            c_ready = ($urandom % 3) != 0;
            lat     = $urandom_range(1, 4);
        end
        RST           = c_rst;
        bus.MEM_WAIT  = c_wait;
        bus.JMP_DO    = c_jmp;
        bus.JMP_PC    = c_jpc;
        bus.OUT_READY = c_ready;
        if (c_rst) begin
            mmu_addr.delete(); mmu_due.delete(); mmu_last_due = 0;
            bus.INST_RVALID = 0;
        end else if (mmu_due.size() > 0 && mmu_due[0] <= cyc) begin
            bus.INST_RVALID = 1;
            bus.INST_ROADDR = mmu_addr[0];
            bus.INST_RDATA  = mmu_addr[0] ^ 32'hDEAD_0000;
            void'(mmu_addr.pop_front());
            void'(mmu_due.pop_front());
        end else begin
            // an unsolicited response with nothing outstanding must be ignored
            bus.INST_RVALID = rnd && (mmu_due.size() == 0) && (($urandom % 8) == 0);
            bus.INST_ROADDR = $urandom;
            bus.INST_RDATA  = $urandom;
        end
        @(negedge CLK);
        if (m_known) begin
            chk("rden",   32'(bus.INST_RDEN), 32'(exp_rden()));
            chk("riaddr", bus.INST_RIADDR, m_pc);
            chk("valid",  32'(bus.OUT_VALID), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                m_last_pc   = m_q[0][63:32];
                m_last_data = m_q[0][31:0];
            end
            chk("out_pc",   bus.OUT_PC, m_last_pc);
            chk("out_data", bus.OUT_DATA, m_last_data);
            chk("count",    32'(bus.COUNT), 32'(m_q.size()));
        end
        if (32'(bus.COUNT) > maxc) maxc = 32'(bus.COUNT);
        if (bus.OUT_VALID === 1'b1 && bus.OUT_READY && !bus.JMP_DO && !RST)
            acc_log.push_back(bus.OUT_PC);
        d_rden = (bus.INST_RDEN === 1'b1);
        d_addr = bus.INST_RIADDR;
        if (d_rden) req_log.push_back(d_addr);
    endtask

    task automatic do_reset();
        c_rst = 1; c_jmp = 0; c_wait = 0;
        cycle();
        c_rst = 0;
    endtask

    initial begin
        RST = 1;
        bus.MEM_WAIT = 0; bus.JMP_DO = 0; bus.JMP_PC = 0; bus.OUT_READY = 1;
        bus.INST_RVALID = 0; bus.INST_ROADDR = 0; bus.INST_RDATA = 0;

        // reset state
        do_reset();
        chk("rst_count",  32'(bus.COUNT), 0);
        chk("rst_valid",  32'(bus.OUT_VALID), 0);
        chk("rst_out_pc", bus.OUT_PC, 0);
        chk("rst_rden",   32'(bus.INST_RDEN), 0);
        chk("rst_addr",   bus.INST_RIADDR, START);

        // streaming, 1-cycle MMU
        c_ready = 1; lat = 1; acc_log.delete(); maxc = 0;
        repeat (20) cycle();
        $display("stream: accepted=%0d maxcount=%0d", acc_log.size(), maxc);
        chk("stream_pc0", get(acc_log, 0), 32'h0);
        chk("stream_pc1", get(acc_log, 1), 32'h4);
        chk("stream_pc2", get(acc_log, 2), 32'h8);
        chk("stream_pc3", get(acc_log, 3), 32'hC);
        chk("stream_rate", acc_log.size(), 18);
        chk("stream_maxcount", 32'(maxc <= 1), 1);

        // backpressure
        do_reset();
        req_log.delete(); c_ready = 0;
        repeat (10) cycle();
        $display("backpressure: requests=%0d count=%0d", req_log.size(), bus.COUNT);
        chk("bp_requests", req_log.size(), 4);
        chk("bp_count", 32'(bus.COUNT), 4);
        chk("bp_rden", 32'(bus.INST_RDEN), 0);
        req_log.delete(); acc_log.delete(); c_ready = 1;
        repeat (12) cycle();
        chk("bp_drain0", get(acc_log, 0), 32'h0);
        chk("bp_drain1", get(acc_log, 1), 32'h4);
        chk("bp_drain2", get(acc_log, 2), 32'h8);
        chk("bp_drain3", get(acc_log, 3), 32'hC);
        chk("bp_resume", get(req_log, 0), 32'h10);

        // MEM_WAIT at pc=0x20
        do_reset();
        repeat (8) cycle();
        c_wait = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            $display("memwait %0d: rden=%0b addr=%h", i, bus.INST_RDEN, bus.INST_RIADDR);
            chk("wait_rden", 32'(bus.INST_RDEN), 0);
            chk("wait_addr", bus.INST_RIADDR, 32'h20);
        end
        c_wait = 0; req_log.delete();
        cycle();
        chk("wait_release", get(req_log, 0), 32'h20);
        repeat (3) cycle();

        // redirect with two reads in flight, 3-cycle MMU
        do_reset();
        lat = 3;
        repeat (2) cycle();
        c_jmp = 1; c_jpc = 32'h100;
        cycle();
        chk("jmp_rden", 32'(bus.INST_RDEN), 0);
        c_jmp = 0; acc_log.delete();
        repeat (12) cycle();
        $display("redirect: first=%h second=%h", get(acc_log, 0), get(acc_log, 1));
        chk("jmp_pc0", get(acc_log, 0), 32'h100);
        chk("jmp_pc1", get(acc_log, 1), 32'h104);

        // redirect coincident with a response, misaligned target
        do_reset();
        lat = 2;
        repeat (2) cycle();
        req_log.delete(); acc_log.delete();
        c_jmp = 1; c_jpc = 32'h203;
        cycle();
        c_jmp = 0;
        repeat (10) cycle();
        $display("coincident: req=%h acc=%h", get(req_log, 0), get(acc_log, 0));
        chk("coin_req0", get(req_log, 0), 32'h200);
        chk("coin_acc0", get(acc_log, 0), 32'h200);
        chk("coin_acc1", get(acc_log, 1), 32'h204);

        // reset with a full queue
        do_reset();
        lat = 1; c_ready = 0;
        repeat (8) cycle();
        chk("full_count", 32'(bus.COUNT), 4);
        c_rst = 1;
        cycle();
        c_rst = 0;
        cycle();
        $display("midreset: count=%0d valid=%0b addr=%h", bus.COUNT, bus.OUT_VALID, bus.INST_RIADDR);
        chk("mrst_count", 32'(bus.COUNT), 0);
        chk("mrst_valid", 32'(bus.OUT_VALID), 0);
        chk("mrst_addr",  bus.INST_RIADDR, START);
        c_ready = 1; acc_log.delete();
        repeat (6) cycle();
        chk("mrst_restart", get(acc_log, 0), START);

        // randomized traffic against the reference
        rnd = 1;
        repeat (3000) cycle();
        rnd = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
